// File: rtl/conv_pkg.sv
// conv_pkg: shared constants and arithmetic helpers for the conv/pool stream.
package conv_pkg;
    localparam int COEF_BIAS_ADDR = 9;
    localparam int COEF_CENTRE_ADDR = 4;
    localparam int NUM_COEF = 10;

    function automatic int acc_width(input int dw, input int cw);
        return dw + cw + 5;
    endfunction

    // ReLU then clamp to the unsigned pixel range of width dw
    function automatic logic [31:0] relu_sat(input logic signed [63:0] v, input int dw);
        logic signed [63:0] mx;
        mx = (64'sd1 <<< dw) - 64'sd1;
        return (v < 0) ? 32'd0 : ((v > mx) ? mx[31:0] : v[31:0]);
    endfunction
endpackage

// File: rtl/line_buffer.sv
// line_buffer: one image row of pixels, read-before-write at the column address.
module line_buffer #(
    parameter int DEPTH = 32,
    parameter int DW = 8
) (
    input  logic                     clk,
    input  logic                     en,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic [DW-1:0]            din,
    output logic [DW-1:0]            dout
);
    logic [DW-1:0] mem [0:(2**$clog2(DEPTH))-1];

    assign dout = mem[addr];

    always_ff @(posedge clk) begin
        if (en) mem[addr] <= din;
    end
endmodule

// File: rtl/conv_pool_stream.sv
// conv_pool_stream: streaming 3x3 convolution with optional 2x2 max-pool.
// Pixels arrive in raster order; results leave through a registered valid/ready port.
module conv_pool_stream
    import conv_pkg::*;
#(
    parameter int IMG_W = 32,
    parameter int IMG_H = 32,
    parameter int DW = 8,
    parameter int CW = 8,
    parameter int SHIFT = 0,
    parameter int POOL_EN = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 coef_we,
    input  logic [3:0]           coef_addr,
    input  logic signed [CW-1:0] coef_data,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic [DW-1:0]        s_data,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [DW-1:0]        m_data,
    output logic                 m_last,
    output logic                 busy
);
    localparam int CLW = $clog2(IMG_W);
    localparam int RWW = $clog2(IMG_H);
    localparam int AW = acc_width(DW, CW);
    localparam int PW = (IMG_W - 2) / 2;
    localparam int PH = (IMG_H - 2) / 2;
    localparam int PBD = 2 ** (CLW - 1);

    logic [CLW-1:0]        col, cc;
    logic [RWW-1:0]        row, cr;
    logic                  accept, last_px, col_end;
    logic [DW-1:0]         rd0, rd1;
    logic [DW-1:0]         win [0:2][0:2];
    logic [DW-1:0]         nw [0:2][0:2];
    logic signed [CW-1:0]  coef [0:NUM_COEF-1];
    logic signed [AW-1:0]  acc, acc_sh, px, kx;
    logic [DW-1:0]         conv_val, h_max, pair, pool_val, out_val;
    logic [DW-1:0]         pool_buf [0:PBD-1];
    logic                  conv_fire, pool_ok, pool_fire, pool_last, out_fire, out_last;

    assign s_ready = !m_valid || m_ready;
    assign accept = s_valid && s_ready;
    assign col_end = col == CLW'(IMG_W - 1);
    assign last_px = col_end && (row == RWW'(IMG_H - 1));
    assign cc = col - CLW'(2);
    assign cr = row - RWW'(2);

    line_buffer #(.DEPTH(IMG_W), .DW(DW)) u_lb0 (
        .clk(clk), .en(accept), .addr(col), .din(s_data), .dout(rd0)
    );
    line_buffer #(.DEPTH(IMG_W), .DW(DW)) u_lb1 (
        .clk(clk), .en(accept), .addr(col), .din(rd0), .dout(rd1)
    );

    // Window as it will look after this pixel: shift left, new column on the right
    always_comb begin
        for (int r = 0; r < 3; r++) begin
            nw[r][0] = win[r][1];
            nw[r][1] = win[r][2];
        end
        nw[0][2] = rd1;
        nw[1][2] = rd0;
        nw[2][2] = s_data;
    end

    always_comb begin
        acc = {{(AW-CW){coef[COEF_BIAS_ADDR][CW-1]}}, coef[COEF_BIAS_ADDR]};
        px = '0;
        kx = '0;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                px = {{(AW-DW){1'b0}}, nw[r][c]};
                kx = {{(AW-CW){coef[r*3+c][CW-1]}}, coef[r*3+c]};
                acc = acc + px * kx;
            end
        end
        acc_sh = acc >>> SHIFT;
        conv_val = DW'(relu_sat({{(64-AW){acc_sh[AW-1]}}, acc_sh}, DW));
    end

    assign conv_fire = accept && (row >= RWW'(2)) && (col >= CLW'(2));
    assign pool_ok = (cc < CLW'(2 * PW)) && (cr < RWW'(2 * PH));
    assign pair = (h_max > conv_val) ? h_max : conv_val;
    assign pool_val = (pool_buf[cc[CLW-1:1]] > pair) ? pool_buf[cc[CLW-1:1]] : pair;
    assign pool_fire = conv_fire && pool_ok && cc[0] && cr[0];
    assign pool_last = (cc == CLW'(2 * PW - 1)) && (cr == RWW'(2 * PH - 1));
    assign out_fire = (POOL_EN != 0) ? pool_fire : conv_fire;
    assign out_val = (POOL_EN != 0) ? pool_val : conv_val;
    assign out_last = (POOL_EN != 0) ? pool_last : last_px;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col <= '0;
            row <= '0;
            busy <= 1'b0;
            m_valid <= 1'b0;
            m_data <= '0;
            m_last <= 1'b0;
            h_max <= '0;
            for (int i = 0; i < NUM_COEF; i++)
                coef[i] <= (i == COEF_CENTRE_ADDR) ? CW'(1) : '0;
            for (int r = 0; r < 3; r++)
                for (int c = 0; c < 3; c++)
                    win[r][c] <= '0;
            for (int i = 0; i < PBD; i++)
                pool_buf[i] <= '0;
        end else begin
            if (accept) begin
                col <= col_end ? '0 : col + CLW'(1);
                row <= col_end ? (last_px ? '0 : row + RWW'(1)) : row;
                busy <= !last_px;
                for (int r = 0; r < 3; r++)
                    for (int c = 0; c < 3; c++)
                        win[r][c] <= nw[r][c];
            end
            if (coef_we && !busy)
                for (int i = 0; i < NUM_COEF; i++)
                    if (coef_addr == 4'(i)) coef[i] <= coef_data;
            // Even conv column opens a horizontal pair; odd column closes it
            if (conv_fire && !cc[0]) h_max <= conv_val;
            if (conv_fire && pool_ok && cc[0] && !cr[0]) pool_buf[cc[CLW-1:1]] <= pair;
            if (out_fire) begin
                m_valid <= 1'b1;
                m_data <= out_val;
                m_last <= out_last;
            end else if (m_ready) begin
                m_valid <= 1'b0;
                m_last <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_conv_pool_stream.sv
// tb_conv_pool_stream: conv-only and pooled instances fed in lockstep, checked
// against an arithmetic model of the convolution, ReLU/saturation and 2x2 max-pool.
module tb_conv_pool_stream;
    localparam int W = 6;
    localparam int H = 6;
    localparam int NP = W * H;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic coef_we = 1'b0;
    logic [3:0] coef_addr = '0;
    logic signed [7:0] coef_data = '0;
    logic drv_valid = 1'b0;
    logic [7:0] s_data = '0;
    logic m_ready = 1'b1;
    logic s_valid;
    logic rdy0, rdy1, mv0, mv1, ml0, ml1, busy0, busy1;
    logic [7:0] md0, md1;

    int errors = 0;
    int checks = 0;
    int rmode = 0;
    logic man_ready = 1'b1;
    int k [0:9];
    int img [0:NP-1];
    int exp0[$], exp1[$], got0[$], got1[$];
    bit expl0[$], expl1[$], gotl0[$], gotl1[$];

    always #5 clk = ~clk;
    assign s_valid = drv_valid && rdy0 && rdy1;

    conv_pool_stream #(.IMG_W(W), .IMG_H(H), .DW(8), .CW(8), .SHIFT(0), .POOL_EN(0)) dut0 (
        .clk(clk), .rst(rst), .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
        .s_valid(s_valid), .s_ready(rdy0), .s_data(s_data), .m_valid(mv0), .m_ready(m_ready),
        .m_data(md0), .m_last(ml0), .busy(busy0)
    );
    conv_pool_stream #(.IMG_W(W), .IMG_H(H), .DW(8), .CW(8), .SHIFT(0), .POOL_EN(1)) dut1 (
        .clk(clk), .rst(rst), .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
        .s_valid(s_valid), .s_ready(rdy1), .s_data(s_data), .m_valid(mv1), .m_ready(m_ready),
        .m_data(md1), .m_last(ml1), .busy(busy1)
    );

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    always @(posedge clk) begin
        #1;
        m_ready = (rmode == 0) ? 1'b1 : (rmode == 1) ? ($urandom_range(0, 3) != 0) : man_ready;
    end

    // Output collectors; a stalled output must reappear unchanged at the next sample
    logic pv0 = 0, pv1 = 0, pl0 = 0, pl1 = 0;
    logic [7:0] pd0 = 0, pd1 = 0;
    always @(negedge clk) begin
        if (pv0 && !rst) chk("hold0", {mv0, ml0, md0}, {1'b1, pl0, pd0});
        if (pv1 && !rst) chk("hold1", {mv1, ml1, md1}, {1'b1, pl1, pd1});
        if (mv0 && m_ready && !rst) begin got0.push_back(md0); gotl0.push_back(ml0); end
        if (mv1 && m_ready && !rst) begin got1.push_back(md1); gotl1.push_back(ml1); end
        pv0 = mv0 && !m_ready && !rst; pd0 = md0; pl0 = ml0;
        pv1 = mv1 && !m_ready && !rst; pd1 = md1; pl1 = ml1;
    end

    function automatic int post(input int a);
        return (a < 0) ? 0 : (a > 255) ? 255 : a;
    endfunction

    task automatic model_frame();
        int cv [0:H-3][0:W-3];
        int s, m;
        for (int r = 0; r < H - 2; r++)
            for (int c = 0; c < W - 2; c++) begin
                s = k[9];
                for (int i = 0; i < 3; i++)
                    for (int j = 0; j < 3; j++)
                        s += k[i*3+j] * img[(r+i)*W + c + j];
                cv[r][c] = post(s);
                exp0.push_back(cv[r][c]);
                expl0.push_back(r == H - 3 && c == W - 3);
            end
        for (int pr = 0; pr < (H - 2) / 2; pr++)
            for (int pc = 0; pc < (W - 2) / 2; pc++) begin
                m = 0;
                for (int i = 0; i < 2; i++)
                    for (int j = 0; j < 2; j++)
                        if (cv[2*pr+i][2*pc+j] > m) m = cv[2*pr+i][2*pc+j];
                exp1.push_back(m);
                expl1.push_back(pr == (H - 2) / 2 - 1 && pc == (W - 2) / 2 - 1);
            end
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1; drv_valid = 1'b0; coef_we = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 10; i++) k[i] = (i == 4) ? 1 : 0;
    endtask

    task automatic write_coef(input int a, input int d);
        coef_we = 1'b1; coef_addr = 4'(a); coef_data = 8'(d);
        @(posedge clk); #1 coef_we = 1'b0;
    endtask

    task automatic send_frame(input int n, input int gaps, input int we_at);
        int t;
        for (int p = 0; p < n; p++) begin
            if (gaps != 0 && $urandom_range(0, 2) == 0) @(posedge clk);
            #0;
            s_data = 8'(img[p]); drv_valid = 1'b1;
            if (p == we_at) begin coef_we = 1'b1; coef_addr = 4'd4; coef_data = 8'sd2; end
            t = 0;
            @(negedge clk);
            while (!(rdy0 && rdy1)) begin
                t++;
                if (t > 300) begin
                    chk("s_ready_timeout", 0, 1);
                    $fatal(1, "input stalled");
                end
                @(negedge clk);
            end
            @(posedge clk); #1;
            drv_valid = 1'b0; coef_we = 1'b0;
            if (p == 0) chk("busy_start", {busy0, busy1}, 2'b11);
            if (p == NP - 1) chk("busy_end", {busy0, busy1}, 2'b00);
        end
    endtask

    task automatic drain();
        int t = 0;
        while ((got0.size() < exp0.size() || got1.size() < exp1.size()) && t < 400) begin
            @(posedge clk); t++;
        end
        repeat (6) @(posedge clk);
    endtask

    task automatic compare(input string tag);
        chk({tag, "_cnt0"}, got0.size(), exp0.size());
        chk({tag, "_cnt1"}, got1.size(), exp1.size());
        for (int i = 0; i < exp0.size() && i < got0.size(); i++) begin
            chk($sformatf("%s_conv[%0d]", tag, i), got0[i], exp0[i]);
            chk($sformatf("%s_convlast[%0d]", tag, i), int'(gotl0[i]), int'(expl0[i]));
        end
        for (int i = 0; i < exp1.size() && i < got1.size(); i++) begin
            chk($sformatf("%s_pool[%0d]", tag, i), got1[i], exp1[i]);
            chk($sformatf("%s_poollast[%0d]", tag, i), int'(gotl1[i]), int'(expl1[i]));
        end
        exp0.delete(); exp1.delete(); got0.delete(); got1.delete();
        expl0.delete(); expl1.delete(); gotl0.delete(); gotl1.delete();
    endtask

    task automatic set_img(input int pat);
        for (int p = 0; p < NP; p++)
            img[p] = (pat == 0) ? p : (pat == 1) ? 30 : (pat == 2) ? 5 : int'($urandom_range(0, 255));
    endtask

    typedef struct {
        int pat;
        int kern;
        int bias;
        int rm;
        int n0;
        int n1;
        int v_first;
        int v_end;
    } vec_t;

    vec_t vecs [0:5];
    int ramp_exp [0:15];
    int pool_exp [0:3];
    int hold;

    initial begin
        vecs[0] = '{0, 0, 0, 0, 16, 4, 7, 28};
        vecs[1] = '{1, 1, 0, 0, 16, 4, 255, 255};
        vecs[2] = '{2, 2, 10, 1, 16, 4, 0, 0};
        vecs[3] = '{3, 3, 0, 1, 16, 4, -1, -1};
        vecs[4] = '{3, 3, 0, 0, 16, 4, -1, -1};
        vecs[5] = '{0, 0, 0, 1, 16, 4, 7, 28};
        ramp_exp = '{7, 8, 9, 10, 13, 14, 15, 16, 19, 20, 21, 22, 25, 26, 27, 28};
        pool_exp = '{14, 16, 26, 28};

        do_reset();
        @(negedge clk);
        chk("rst_out0", {mv0, ml0, md0, busy0, rdy0}, {1'b0, 1'b0, 8'd0, 1'b0, 1'b1});
        chk("rst_out1", {mv1, ml1, md1, busy1, rdy1}, {1'b0, 1'b0, 8'd0, 1'b0, 1'b1});

        for (int v = 0; v < 6; v++) begin
            set_img(vecs[v].pat);
            for (int i = 0; i < 9; i++)
                k[i] = (vecs[v].kern == 0) ? (i == 4) : (vecs[v].kern == 1) ? 1 :
                       (vecs[v].kern == 2) ? -1 : int'($urandom_range(0, 14)) - 7;
            k[9] = (vecs[v].kern == 3) ? int'($urandom_range(0, 40)) - 20 : vecs[v].bias;
            for (int i = 0; i < 10; i++) write_coef(i, k[i]);
            model_frame();
            rmode = vecs[v].rm;
            send_frame(NP, vecs[v].rm, -1);
            drain();
            chk($sformatf("vec%0d_n0", v), got0.size(), vecs[v].n0);
            chk($sformatf("vec%0d_n1", v), got1.size(), vecs[v].n1);
            if (vecs[v].v_first >= 0 && got0.size() > 0)
                chk($sformatf("vec%0d_first", v), got0[0], vecs[v].v_first);
            if (vecs[v].v_end >= 0 && got1.size() > 0)
                chk($sformatf("vec%0d_end", v), got1[got1.size()-1], vecs[v].v_end);
            compare($sformatf("vec%0d", v));
            rmode = 0;
        end

        // Back-pressure: hold m_ready low for five cycles once output is pending
        do_reset();
        set_img(0);
        model_frame();
        rmode = 2; man_ready = 1'b0;
        @(posedge clk); #1;
        fork
            send_frame(NP, 0, -1);
        join_none
        begin
            int t = 0;
            @(negedge clk);
            while (!mv0 && t < 300) begin @(negedge clk); t++; end
        end
        chk("stall_reach", mv0, 1);
        hold = md0;
        repeat (5) begin
            @(negedge clk);
            chk("stall_sready", rdy0, 0);
            chk("stall_data", md0, hold);
        end
        rmode = 0; man_ready = 1'b1;
        wait fork;
        drain();
        for (int i = 0; i < 16 && i < got0.size(); i++) chk($sformatf("ramp[%0d]", i), got0[i], ramp_exp[i]);
        for (int i = 0; i < 4 && i < got1.size(); i++) chk($sformatf("rpool[%0d]", i), got1[i], pool_exp[i]);
        compare("stall");

        // Coefficient writes while busy or to an unused address are dropped
        write_coef(12, 5);
        set_img(0);
        model_frame();
        send_frame(NP, 0, 18);
        drain();
        compare("coef_busy");

        // Reset mid-frame, then a clean frame
        set_img(0);
        send_frame(18, 0, -1);
        do_reset();
        #1;
        chk("midrst_out0", {mv0, ml0, md0, busy0}, {1'b0, 1'b0, 8'd0, 1'b0});
        got0.delete(); got1.delete(); gotl0.delete(); gotl1.delete();
        model_frame();
        send_frame(NP, 0, -1);
        drain();
        for (int i = 0; i < 16 && i < got0.size(); i++) chk($sformatf("rst_ramp[%0d]", i), got0[i], ramp_exp[i]);
        compare("midrst");

        // Back-to-back frames with no idle cycle between them
        set_img(0);
        model_frame();
        send_frame(NP, 0, -1);
        set_img(3);
        model_frame();
        send_frame(NP, 0, -1);
        drain();
        compare("b2b");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule
